// File: rtl/fp4_mul_arbiter.sv
// Two-port round-robin front end for a pipelined fp4 multiplier. Per-port credits
// bound the in-flight work so each port's result FIFO can never overflow.
module fp4_mul_arbiter #(
    parameter int LAT   = 4,
    parameter int DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,

    input  logic       i_req0_valid,
    output logic       o_req0_ready,
    input  logic [3:0] i_req0_a,
    input  logic [3:0] i_req0_b,

    input  logic       i_req1_valid,
    output logic       o_req1_ready,
    input  logic [3:0] i_req1_a,
    input  logic [3:0] i_req1_b,

    output logic       o_mul_valid,
    output logic [3:0] o_mul_a,
    output logic [3:0] o_mul_b,

    input  logic       i_mul_valid,
    input  logic       i_mul_sign,
    input  logic [2:0] i_mul_exp_u,
    input  logic [4:0] i_mul_sig_grs,

    output logic       o_rsp0_valid,
    input  logic       i_rsp0_ready,
    output logic       o_rsp0_sign,
    output logic [2:0] o_rsp0_exp_u,
    output logic [4:0] o_rsp0_sig_grs,

    output logic       o_rsp1_valid,
    input  logic       i_rsp1_ready,
    output logic       o_rsp1_sign,
    output logic [2:0] o_rsp1_exp_u,
    output logic [4:0] o_rsp1_sig_grs,

    output logic       o_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CREDIT_MAX = CW'(DEPTH);
    localparam logic [AW:0]   PTR_ONE    = (AW + 1)'(1);

    logic [1:0] reqValid;
    logic [1:0] rspReady;
    logic [1:0] eligible;
    logic [1:0] request;
    logic [1:0] grant;
    logic [1:0] push;
    logic [1:0] pop;
    logic [1:0] orphan;
    logic [1:0] rspValid;
    logic       stray;
    logic       tagValidOut;
    logic       tagPortOut;
    logic [8:0] resData;
    logic [8:0] rspHead [2];

    logic           mulValid_q;
    logic [3:0]     mulA_q;
    logic [3:0]     mulB_q;
    logic           mulPort_q;
    logic           rr_q;
    logic           err_q;
    logic [LAT-1:0] tagValid_q;
    logic [LAT-1:0] tagPort_q;
    logic [CW-1:0]  cnt_q [2];
    logic [CW-1:0]  cnt_d [2];
    logic [AW:0]    wrPtr_q [2];
    logic [AW:0]    rdPtr_q [2];
    logic [8:0]     mem_q [2][DEPTH];

    assign tagValidOut = tagValid_q[LAT-1];
    assign tagPortOut  = tagPort_q[LAT-1];
    assign resData     = {i_mul_sign, i_mul_exp_u, i_mul_sig_grs};

    // rr_q == 0 favours port 0. Ready is forced low while reset is asserted.
    always_comb begin
        reqValid = {i_req1_valid, i_req0_valid};
        rspReady = {i_rsp1_ready, i_rsp0_ready};
        for (int p = 0; p < 2; p++) begin
            eligible[p] = cnt_q[p] < CREDIT_MAX;
            rspValid[p] = wrPtr_q[p] != rdPtr_q[p];
            rspHead[p]  = rspValid[p] ? mem_q[p][rdPtr_q[p][AW-1:0]] : 9'd0;
        end
        request  = reqValid & eligible & {2{~i_rst}};
        grant[0] = request[0] & (~request[1] | ~rr_q);
        grant[1] = request[1] & (~request[0] | rr_q);
        pop      = rspValid & rspReady;
        push     = {2{tagValidOut & i_mul_valid}} & {tagPortOut, ~tagPortOut};
        orphan   = {2{tagValidOut & ~i_mul_valid}} & {tagPortOut, ~tagPortOut};
        stray    = i_mul_valid & ~tagValidOut;
        for (int p = 0; p < 2; p++) begin
            cnt_d[p] = cnt_q[p] + CW'(grant[p]) - CW'(pop[p]) - CW'(orphan[p]);
        end
    end

    // A result landing in the FIFO moves a credit from in-flight to occupancy, so only
    // grants, pops and orphaned tags change the count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mulValid_q <= 1'b0;
            mulA_q     <= '0;
            mulB_q     <= '0;
            mulPort_q  <= 1'b0;
            rr_q       <= 1'b0;
            err_q      <= 1'b0;
            tagValid_q <= '0;
            tagPort_q  <= '0;
            for (int p = 0; p < 2; p++) begin
                cnt_q[p]   <= '0;
                wrPtr_q[p] <= '0;
                rdPtr_q[p] <= '0;
            end
        end else begin
            mulValid_q <= |grant;
            if (|grant) begin
                mulA_q    <= grant[1] ? i_req1_a : i_req0_a;
                mulB_q    <= grant[1] ? i_req1_b : i_req0_b;
                mulPort_q <= grant[1];
                rr_q      <= grant[0];
            end
            tagValid_q[0] <= mulValid_q;
            tagPort_q[0]  <= mulPort_q;
            for (int i = 1; i < LAT; i++) begin
                tagValid_q[i] <= tagValid_q[i-1];
                tagPort_q[i]  <= tagPort_q[i-1];
            end
            if (stray || (|orphan)) begin
                err_q <= 1'b1;
            end
            for (int p = 0; p < 2; p++) begin
                cnt_q[p] <= cnt_d[p];
                if (push[p]) begin
                    wrPtr_q[p] <= wrPtr_q[p] + PTR_ONE;
                end
                if (pop[p]) begin
                    rdPtr_q[p] <= rdPtr_q[p] + PTR_ONE;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        for (int p = 0; p < 2; p++) begin
            if (push[p]) begin
                mem_q[p][wrPtr_q[p][AW-1:0]] <= resData;
            end
        end
    end

    assign o_req0_ready = grant[0];
    assign o_req1_ready = grant[1];
    assign o_mul_valid  = mulValid_q;
    assign o_mul_a      = mulA_q;
    assign o_mul_b      = mulB_q;
    assign o_rsp0_valid = rspValid[0];
    assign o_rsp1_valid = rspValid[1];
    assign {o_rsp0_sign, o_rsp0_exp_u, o_rsp0_sig_grs} = rspHead[0];
    assign {o_rsp1_sign, o_rsp1_exp_u, o_rsp1_sig_grs} = rspHead[1];
    assign o_err        = err_q;

endmodule

// File: tb/tb_fp4_mul_arbiter.sv
// Scoreboard bench for fp4_mul_arbiter with a LAT-cycle multiplier stand-in that
// computes a simple fp4 product so results can be traced back to their operands.
module tb_fp4_mul_arbiter;

    localparam int LAT   = 4;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       req0Valid, req1Valid;
    logic [3:0] req0A, req0B, req1A, req1B;
    logic       req0Ready, req1Ready;
    logic       mulValid;
    logic [3:0] mulA, mulB;
    logic       mulResValid, mulResSign;
    logic [2:0] mulResExp;
    logic [4:0] mulResSig;
    logic       rsp0Valid, rsp0Ready, rsp0Sign;
    logic [2:0] rsp0Exp;
    logic [4:0] rsp0Sig;
    logic       rsp1Valid, rsp1Ready, rsp1Sign;
    logic [2:0] rsp1Exp;
    logic [4:0] rsp1Sig;
    logic       errFlag;
    logic       injectStray;

    int checkCount;
    int errorCount;
    int grantCount0;
    int grantCount1;
    int g0, g1, g0Mid, stale;

    logic [7:0] issueQ[$];
    logic [8:0] rspQ0[$];
    logic [8:0] rspQ1[$];

    logic [LAT-1:0] mvPipe;
    logic [8:0]     mdPipe [LAT];

    fp4_mul_arbiter #(.LAT(LAT), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(req0Valid), .o_req0_ready(req0Ready), .i_req0_a(req0A), .i_req0_b(req0B),
        .i_req1_valid(req1Valid), .o_req1_ready(req1Ready), .i_req1_a(req1A), .i_req1_b(req1B),
        .o_mul_valid(mulValid), .o_mul_a(mulA), .o_mul_b(mulB),
        .i_mul_valid(mulResValid), .i_mul_sign(mulResSign), .i_mul_exp_u(mulResExp),
        .i_mul_sig_grs(mulResSig),
        .o_rsp0_valid(rsp0Valid), .i_rsp0_ready(rsp0Ready), .o_rsp0_sign(rsp0Sign),
        .o_rsp0_exp_u(rsp0Exp), .o_rsp0_sig_grs(rsp0Sig),
        .o_rsp1_valid(rsp1Valid), .i_rsp1_ready(rsp1Ready), .o_rsp1_sign(rsp1Sign),
        .o_rsp1_exp_u(rsp1Exp), .o_rsp1_sig_grs(rsp1Sig),
        .o_err(errFlag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Product of two packed {s,e[1:0],m} values; the hidden bit is 1 unless e is zero.
    function automatic logic [8:0] fp4Mul(input logic [3:0] a, input logic [3:0] b);
        logic [1:0] sigA, sigB;
        logic [3:0] prod;
        logic [2:0] expU;
        sigA = {|a[2:1], a[0]};
        sigB = {|b[2:1], b[0]};
        prod = {2'b00, sigA} * {2'b00, sigB};
        expU = {1'b0, a[2:1]} + {1'b0, b[2:1]} + {2'b00, prod[3]};
        return {a[3] ^ b[3], expU, prod, 1'b0};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mvPipe <= '0;
            for (int i = 0; i < LAT; i++) mdPipe[i] <= '0;
        end else begin
            mvPipe[0] <= mulValid;
            mdPipe[0] <= fp4Mul(mulA, mulB);
            for (int i = 1; i < LAT; i++) begin
                mvPipe[i] <= mvPipe[i-1];
                mdPipe[i] <= mdPipe[i-1];
            end
        end
    end

    assign mulResValid = mvPipe[LAT-1] | injectStray;
    assign {mulResSign, mulResExp, mulResSig} = injectStray ? 9'h1AB : mdPipe[LAT-1];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [3:0] a0, input logic [3:0] b0,
                                 input logic v1, input logic [3:0] a1, input logic [3:0] b1);
        req0Valid = v0; req0A = a0; req0B = b0;
        req1Valid = v1; req1A = a1; req1B = b1;
    endtask

    task automatic resetDut();
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0);
        rsp0Ready   = 1'b0;
        rsp1Ready   = 1'b0;
        injectStray = 1'b0;
        rst = 1'b1;
        issueQ.delete();
        rspQ0.delete();
        rspQ1.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Mid-cycle view of what the next rising edge will transfer.
    always @(negedge clk) begin
        if (!rst) begin
            if (mulValid) begin
                if (issueQ.size() == 0) checkOutput("mul_issue_unexpected", 32'd1, 32'd0);
                else checkOutput("mul_ab", 32'({mulA, mulB}), 32'(issueQ.pop_front()));
            end
            if (req0Ready && req1Ready) checkOutput("both_ready", 32'd1, 32'd0);
            if (req0Valid && req0Ready) begin
                issueQ.push_back({req0A, req0B});
                rspQ0.push_back(fp4Mul(req0A, req0B));
                grantCount0++;
            end
            if (req1Valid && req1Ready) begin
                issueQ.push_back({req1A, req1B});
                rspQ1.push_back(fp4Mul(req1A, req1B));
                grantCount1++;
            end
            if (rsp0Valid && rsp0Ready) begin
                if (rspQ0.size() == 0) checkOutput("rsp0_unexpected", 32'd1, 32'd0);
                else checkOutput("rsp0_data", 32'({rsp0Sign, rsp0Exp, rsp0Sig}), 32'(rspQ0.pop_front()));
            end
            if (rsp1Valid && rsp1Ready) begin
                if (rspQ1.size() == 0) checkOutput("rsp1_unexpected", 32'd1, 32'd0);
                else checkOutput("rsp1_data", 32'({rsp1Sign, rsp1Exp, rsp1Sig}), 32'(rspQ1.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checkCount = 0; errorCount = 0; grantCount0 = 0; grantCount1 = 0;
        injectStray = 1'b0; rsp0Ready = 1'b0; rsp1Ready = 1'b0;
        rst = 1'b1;
        applyStimulus(1'b1, 4'h3, 4'h3, 1'b1, 4'h5, 4'h5);
        #3;
        checkOutput("rst_req0_ready", 32'(req0Ready), 32'd0);
        checkOutput("rst_req1_ready", 32'(req1Ready), 32'd0);
        checkOutput("rst_mul_valid", 32'(mulValid), 32'd0);
        checkOutput("rst_mul_ab", 32'({mulA, mulB}), 32'd0);
        checkOutput("rst_rsp_valid", 32'({rsp1Valid, rsp0Valid}), 32'd0);
        checkOutput("rst_err", 32'(errFlag), 32'd0);
        resetDut();

        // Single port-0 op: latency and the worked 1.5*1.5 example.
        rsp0Ready = 1'b1;
        @(posedge clk); #1;
        applyStimulus(1'b1, 4'b0011, 4'b0011, 1'b0, 4'h0, 4'h0);
        @(negedge clk);
        checkOutput("single_req0_ready", 32'(req0Ready), 32'd1);
        @(posedge clk); #1;
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0);
        checkOutput("single_mul_valid", 32'(mulValid), 32'd1);
        checkOutput("single_mul_ab", 32'({mulA, mulB}), 32'h33);
        for (int e = 1; e <= LAT; e++) begin
            @(posedge clk); #1;
            checkOutput("single_rsp0_early", 32'(rsp0Valid), 32'd0);
        end
        @(posedge clk); #1;
        checkOutput("single_rsp0_valid", 32'(rsp0Valid), 32'd1);
        checkOutput("single_rsp0_sign", 32'(rsp0Sign), 32'd0);
        checkOutput("single_rsp0_exp", 32'(rsp0Exp), 32'd3);
        checkOutput("single_rsp0_sig", 32'(rsp0Sig), 32'b10010);
        repeat (3) @(posedge clk);
        resetDut();

        // Both ports every cycle: strict alternation starting with port 0.
        rsp0Ready = 1'b1; rsp1Ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            applyStimulus(1'b1, 4'($urandom), 4'($urandom), 1'b1, 4'($urandom), 4'($urandom));
            @(negedge clk);
            checkOutput("rr_grant", 32'({req1Ready, req0Ready}), (i % 2 == 0) ? 32'd1 : 32'd2);
        end
        @(posedge clk); #1;
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0);
        repeat (12) @(posedge clk);
        #1;
        checkOutput("rr_q0_drained", 32'(rspQ0.size()), 32'd0);
        checkOutput("rr_q1_drained", 32'(rspQ1.size()), 32'd0);
        checkOutput("rr_err", 32'(errFlag), 32'd0);
        resetDut();

        // Port 1 back-pressured: DEPTH grants, then one more per pop.
        rsp0Ready = 1'b1; rsp1Ready = 1'b0;
        g0 = grantCount0; g1 = grantCount1; g0Mid = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (c == 8) g0Mid = grantCount0;
            applyStimulus(1'b1, 4'($urandom), 4'($urandom), 1'b1, 4'($urandom), 4'($urandom));
        end
        @(posedge clk); #1;
        checkOutput("bp_p1_grants", 32'(grantCount1 - g1), DEPTH);
        checkOutput("bp_p0_continues", 32'((grantCount0 - g0Mid) >= 6), 32'd1);
        @(negedge clk);
        checkOutput("bp_req1_blocked", 32'(req1Ready), 32'd0);
        checkOutput("bp_rsp1_waiting", 32'(rsp1Valid), 32'd1);
        @(posedge clk); #1;
        g1 = grantCount1;
        rsp1Ready = 1'b1;
        @(posedge clk); #1;
        rsp1Ready = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("bp_p1_one_more", 32'(grantCount1 - g1), 32'd1);
        @(negedge clk);
        checkOutput("bp_req1_blocked_again", 32'(req1Ready), 32'd0);
        resetDut();

        // Stray multiplier result: sticky error, nothing written, credits intact.
        @(posedge clk); #1;
        injectStray = 1'b1;
        @(negedge clk);
        checkOutput("stray_err_before", 32'(errFlag), 32'd0);
        @(posedge clk); #1;
        injectStray = 1'b0;
        checkOutput("stray_err_set", 32'(errFlag), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("stray_err_sticky", 32'(errFlag), 32'd1);
        checkOutput("stray_no_write", 32'({rsp1Valid, rsp0Valid}), 32'd0);
        applyStimulus(1'b1, 4'h5, 4'h6, 1'b1, 4'h7, 4'h2);
        @(negedge clk);
        checkOutput("stray_credit_intact", 32'(req0Ready), 32'd1);
        resetDut();
        checkOutput("stray_err_cleared", 32'(errFlag), 32'd0);

        // Reset with 2 results buffered on port 0 and 3 ops in flight for port 1.
        @(posedge clk); #1;
        for (int c = 0; c < 11; c++) begin
            applyStimulus(c < 2, 4'($urandom), 4'($urandom), c >= 8, 4'($urandom), 4'($urandom));
            @(posedge clk); #1;
        end
        applyStimulus(1'b1, 4'h3, 4'h5, 1'b1, 4'h6, 4'h7);
        checkOutput("mid_rsp0_buffered", 32'(rsp0Valid), 32'd1);
        #2 rst = 1'b1;
        issueQ.delete(); rspQ0.delete(); rspQ1.delete();
        #1;
        checkOutput("mid_rst_ready", 32'({req1Ready, req0Ready}), 32'd0);
        checkOutput("mid_rst_mul", 32'({mulValid, mulA, mulB}), 32'd0);
        checkOutput("mid_rst_rsp0", 32'({rsp0Valid, rsp0Sign, rsp0Exp, rsp0Sig}), 32'd0);
        checkOutput("mid_rst_rsp1", 32'({rsp1Valid, rsp1Sign, rsp1Exp, rsp1Sig}), 32'd0);
        checkOutput("mid_rst_err", 32'(errFlag), 32'd0);
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp0Valid || rsp1Valid) stale++;
        end
        checkOutput("mid_no_stale_rsp", 32'(stale), 32'd0);
        g0 = grantCount0; g1 = grantCount1;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            applyStimulus(1'b1, 4'($urandom), 4'($urandom), 1'b1, 4'($urandom), 4'($urandom));
        end
        @(posedge clk); #1;
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0);
        checkOutput("mid_credits_p0", 32'(grantCount0 - g0), DEPTH);
        checkOutput("mid_credits_p1", 32'(grantCount1 - g1), DEPTH);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/fp4_mul_arbiter.md
FP4_MUL_ARBITER -- requirements
Module: fp4_mul_arbiter

Interface
REQ-001 Parameter LAT, default 4: fp4 multiplier latency, counted in clock edges from an input-valid cycle to its output-valid cycle.
REQ-002 Parameter DEPTH, default 4: result FIFO depth per port; power of two, at least 2.
REQ-003 i_clk  in  1  clock; all state rising-edge.
REQ-004 i_rst  in  1  asynchronous, active-high reset.
REQ-005 i_req0_valid / o_req0_ready  in/out  1/1  port-0 operand handshake.
REQ-006 i_req0_a, i_req0_b  in  4 each  port-0 packed fp4 operands {s,e[1:0],m}.
REQ-007 i_req1_valid / o_req1_ready / i_req1_a / i_req1_b: port 1, same as REQ-005/006.
REQ-008 o_mul_valid, o_mul_a, o_mul_b  out  1/4/4  registered drive to multiplier i_data_valid, a, b.
REQ-009 i_mul_valid, i_mul_sign, i_mul_exp_u, i_mul_sig_grs  in  1/1/3/5  multiplier result.
REQ-010 o_rsp0_valid / i_rsp0_ready  out/in  1/1  port-0 result handshake.
REQ-011 o_rsp0_sign, o_rsp0_exp_u, o_rsp0_sig_grs  out  1/3/5  port-0 result, FIFO head.
REQ-012 o_rsp1_*: port-1 result, same as REQ-010/011.
REQ-013 o_err  out  1  sticky tag/result mismatch flag.

Function
REQ-014 Transfer on a port = valid & ready in the same cycle; ready is combinational from the valids, credits and the RR pointer.
REQ-015 Credit per port p: cnt_p = FIFO occupancy + in-flight ops tagged p; port p eligible only when cnt_p < DEPTH.
REQ-016 Grant at most one port per cycle; o_reqp_ready = grant_p; no ready to an ineligible or non-requesting port.
REQ-017 Round-robin: if both ports are eligible and valid, grant the port named by the rr pointer; if only one, grant it.
REQ-018 After any grant, rr points to the other port; with no grant, rr holds; reset value is port 0.
REQ-019 On the grant edge, register o_mul_valid=1 and o_mul_a/b from the granted port; with no grant, o_mul_valid=0 and o_mul_a/b hold.
REQ-020 Tag pipeline: LAT-deep shift register of {valid, port}, loaded from o_mul_valid and the grant port, aligned so the tag exits with the matching i_mul_valid.
REQ-021 Tag valid with i_mul_valid: write {sign, exp_u, sig_grs} into the tagged port's FIFO on that edge.
REQ-022 i_mul_valid without a tag, or a tag without i_mul_valid: set o_err and drop the result; credits still release for an orphaned tag.
REQ-023 o_err stays set until reset.
REQ-024 FIFOs are first-word-fall-through: o_rspp_valid = FIFO not empty; pop on o_rspp_valid & i_rspp_ready.
REQ-025 o_rsp data = head entry while valid, all-zero while not valid.
REQ-026 Push and pop in the same cycle on one FIFO: both take effect and occupancy is unchanged; full+push cannot occur (credits).
REQ-027 cnt_p: +1 on grant, -1 on pop; a simultaneous grant and pop leave it unchanged. The result write moves one count from in-flight to occupancy, so cnt_p is unchanged.
REQ-028 Latency: a grant at edge k with an empty FIFO raises o_rspp_valid after edge k+LAT+1.
REQ-029 Throughput: one grant per cycle sustained while credits allow; results are in order per port.
REQ-030 Pointer wrap-around: FIFO read/write pointers wrap modulo DEPTH.

Reset
REQ-031 Reset values: o_req*_ready=0, o_mul_valid=0, o_mul_a/b=0, o_rsp*_valid=0, o_rsp* data=0, o_err=0, rr=port 0.
REQ-032 Reset also clears all tags, FIFO pointers and credits.
REQ-033 Reset mid-operation discards in-flight ops and buffered results; the multiplier shares i_rst, so no stale result follows.

Verification
REQ-034 Port 0 only, a=4'b0011, b=4'b0011, rsp0_ready=1 -> o_mul_valid one edge later; o_rsp0_valid after edge k+5 (LAT=4) with sign 0, exp_u 3'd3, sig_grs 5'b10010.
REQ-035 Both ports valid every cycle, both rsp_ready=1 -> grants alternate 0,1,0,1 starting with port 0; each port's results arrive in issue order.
REQ-036 Port 1 rsp_ready=0, valid held -> exactly DEPTH=4 port-1 grants, then o_req1_ready=0; port 0 continues at full rate; raising rsp1_ready for one pop allows one further port-1 grant.
REQ-037 Inject i_mul_valid=1 with the tag pipe empty -> o_err=1 from the next edge on, no FIFO write, credits unchanged; o_err clears only on i_rst.
REQ-038 Assert i_rst with 3 ops in flight and 2 buffered -> all outputs at reset values immediately; after release, no rsp_valid without a new grant and full credits restored.
